writeback_stage: RTL
====================

# writeback_stage

Registered, parametrised writeback stage for the pipelined NAND CPU. It captures one decoded instruction's writeback controls and ALU result, waits when needed for a variable-latency memory read, then presents a single-cycle commit to the register file and predicate-state (ps) register. While an instruction is in flight it also exposes a pending-destination indication for hazard logic, and it aborts a stalled memory read after a bounded timeout.

## Interface
Parameters:
- DATA_W, 16, datapath width of ALU/memory data and wb_data
- RW_ADDR_W, 4, register-file write address width
- PS_BIT, 0, bit of the ALU result copied to wb_ps (must be < DATA_W)
- MEM_TIMEOUT, 15, max cycles spent in WAIT_MEM before abort (>= 1)

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; = (state == IDLE)
- in_use_rw  in  1  instruction writes a register
- in_rw_addr  in  RW_ADDR_W  destination register
- in_mem_access  in  1  result comes from memory read
- in_write_ps  in  1  instruction writes ps
- in_alu_data  in  DATA_W  ALU result
- mem_rvalid  in  1  memory read data valid this cycle
- mem_rdata  in  DATA_W  memory read data
- flush  in  1  kill in-flight/incoming instruction
- wb_valid  out  1  commit pulse
- wb_use_rw, wb_write_ps, wb_ps  out  1 each  commit controls
- wb_rw_addr  out  RW_ADDR_W;  wb_data  out  DATA_W
- pend_valid  out  1  a register write is in flight
- pend_addr  out  RW_ADDR_W  its destination
- mem_timeout  out  1  one-cycle abort pulse

## Operation
- Accept = in_valid & in_ready & ~flush. On accept, latch all in_* fields.
- States: IDLE, WAIT_MEM.
- In IDLE, a non-memory accept schedules a commit for the next cycle and stays in IDLE.
- In IDLE, a memory accept moves to WAIT_MEM and clears the timeout counter.
- In WAIT_MEM, mem_rvalid captures mem_rdata, schedules a commit for the next cycle and returns to IDLE.
- In WAIT_MEM with no mem_rvalid, the counter increments. When the counter reaches MEM_TIMEOUT, the stage pulses mem_timeout next cycle, returns to IDLE and does not commit.
- mem_rvalid in IDLE is ignored.
- Commit values:
  - wb_data = mem data if mem_access, else ALU data.
  - wb_ps = latched ALU data[PS_BIT].
  - wb_use_rw, wb_rw_addr and wb_write_ps come from the latched fields.
- When wb_valid = 0, all wb_* outputs are 0.
- pend_valid = latched use_rw while in WAIT_MEM, or while a scheduled commit is not yet visible. pend_addr is 0 when pend_valid = 0.
- flush:
  - Blocks accept that cycle.
  - In WAIT_MEM, returns the stage to IDLE with no commit. flush wins over a simultaneous mem_rvalid or timeout.
  - Suppresses a commit scheduled for the next cycle.
  - Does not affect a wb_valid pulse already on the outputs this cycle.
- Reset to IDLE with the counter at 0. All outputs are 0 except in_ready, which is 1. rst mid-WAIT_MEM discards the instruction with no commit and no timeout pulse.

## Timing
- Non-memory path: accept at cycle t → wb_valid at t+1, one cycle wide. Sustains one instruction per cycle.
- Memory path: accept at t, in_ready = 0 from t+1. mem_rvalid first sampled at t+1.
  - mem_rvalid at t+k → wb_valid at t+k+1. in_ready = 1 at t+k+1, so a new accept is possible at t+k+1.
- Timeout: with no mem_rvalid, mem_timeout pulses at t+MEM_TIMEOUT+1 and in_ready returns at that cycle.
- pend_valid is high from t+1 until the cycle wb_valid asserts, inclusive of the commit cycle.

## Test plan
- Reset, then non-memory in_alu_data=0x00A5, rw_addr=3, use_rw=1, write_ps=1 at cycle t → at t+1 wb_valid=1, wb_data=0x00A5, wb_rw_addr=3, wb_ps=1; all wb_* are 0 at t+2.
- Back-to-back non-memory accepts on 4 consecutive cycles with data 1..4 → four consecutive commits with data 1..4; in_ready stays 1.
- Memory accept to rw_addr=5, mem_rvalid with 0xBEEF three cycles later → pend_valid=1 and pend_addr=5 meanwhile; wb_data=0xBEEF one cycle after mem_rvalid; in_ready=0 throughout the wait.
- Memory accept with no mem_rvalid (MEM_TIMEOUT=15) → mem_timeout pulses 16 cycles after accept, no wb_valid, in_ready=1 again.
- flush asserted together with mem_rvalid while in WAIT_MEM → no commit, IDLE next cycle. flush together with in_valid in IDLE → no accept, no commit.
- rst asserted mid-WAIT_MEM → next cycle all outputs at reset values. A subsequent mem_rvalid produces no commit.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: registered writeback for the NAND CPU pipeline.
// Captures one instruction's writeback controls and ALU result, optionally
// waits for a memory read (bounded by MEM_TIMEOUT), then issues a one-cycle
// commit to the register file and ps register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            upstream handshake (ready only in IDLE)
//   in_use_rw, in_rw_addr          destination register controls
//   in_mem_access, in_write_ps     result source and ps-write flag
//   in_alu_data                    ALU result
//   mem_rvalid, mem_rdata          memory read response
//   flush                          kill in-flight or incoming instruction
//   wb_*                           commit pulse and controls (zero when idle)
//   pend_valid, pend_addr          in-flight destination for hazard logic
//   mem_timeout                    one-cycle abort pulse
module writeback_stage #(
    parameter int DATA_W      = 16,
    parameter int RW_ADDR_W   = 4,
    parameter int PS_BIT      = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_use_rw,
    input  logic [RW_ADDR_W-1:0] in_rw_addr,
    input  logic                 in_mem_access,
    input  logic                 in_write_ps,
    input  logic [DATA_W-1:0]    in_alu_data,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 flush,
    output logic                 wb_valid,
    output logic                 wb_use_rw,
    output logic                 wb_write_ps,
    output logic                 wb_ps,
    output logic [RW_ADDR_W-1:0] wb_rw_addr,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 pend_valid,
    output logic [RW_ADDR_W-1:0] pend_addr,
    output logic                 mem_timeout
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_use_rw;
    logic [RW_ADDR_W-1:0] r_rw_addr;
    logic                 r_mem;
    logic                 r_write_ps;
    logic [DATA_W-1:0]    r_alu;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_wb_valid;
    logic                 r_timeout;
    logic                 w_accept;

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_use_rw   <= 1'b0;
            r_rw_addr  <= '0;
            r_mem      <= 1'b0;
            r_write_ps <= 1'b0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_wb_valid <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_timeout  <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_use_rw   <= in_use_rw;
                    r_rw_addr  <= in_rw_addr;
                    r_mem      <= in_mem_access;
                    r_write_ps <= in_write_ps;
                    r_alu      <= in_alu_data;
                    if (in_mem_access) begin
                        r_state <= WAIT_MEM;
                        r_cnt   <= '0;
                    end else begin
                        r_wb_valid <= 1'b1;
                    end
                end
            end else if (flush) begin
                r_state <= IDLE;
            end else if (mem_rvalid) begin
                r_rdata    <= mem_rdata;
                r_wb_valid <= 1'b1;
                r_state    <= IDLE;
            end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                // the increment that would reach MEM_TIMEOUT aborts the read instead
                r_timeout <= 1'b1;
                r_state   <= IDLE;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // latched fields stay stable through the commit cycle; a new accept only
    // overwrites them at the end of that cycle
    assign wb_valid    = r_wb_valid;
    assign wb_use_rw   = r_wb_valid & r_use_rw;
    assign wb_write_ps = r_wb_valid & r_write_ps;
    assign wb_ps       = r_wb_valid & r_alu[PS_BIT];
    assign wb_rw_addr  = r_wb_valid ? r_rw_addr : '0;
    assign wb_data     = r_wb_valid ? (r_mem ? r_rdata : r_alu) : '0;
    assign pend_valid  = r_use_rw & ((r_state == WAIT_MEM) | r_wb_valid);
    assign pend_addr   = pend_valid ? r_rw_addr : '0;
    assign mem_timeout = r_timeout;
endmodule
